uart_tx_arbiter: RTL

//   Shares one uart_tx transmitter among NUM_REQ byte producers (CPU MMIO, debug, DMA).

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// uart_arb_pkg : shared types and helpers for the uart_tx arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } arb_state_t;

    // Successor of a requester index with wrap at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick starting at rr_ptr
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       any_req,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int IDW = $clog2(NUM_REQ);

    int w_off;

    function automatic int wrap(input int s);
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // Rotated view: offset k corresponds to requester rr_ptr+k; lowest set offset wins.
    always_comb begin
        w_off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IDW'(wrap(int'(rr_ptr) + k))]) begin
                w_off = k;
            end
        end
    end

    assign any_req = |req;
    assign gnt_idx = IDW'(wrap(int'(rr_ptr) + w_off));

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin, packet-locking share of one uart_tx
// Revision        : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_din,
    input  logic                           tx_done_tick,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arb_state_t           r_state;
    arb_state_t           w_state_d;
    logic [IDW-1:0]       r_rr_ptr;
    logic                 r_lock;
    logic [CW-1:0]        r_cnt;

    logic                 w_any_req;
    logic [IDW-1:0]       w_gnt_idx;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_hold_enter;
    logic [IDW-1:0]       w_acc_idx;
    logic [NUM_REQ-1:0]   w_ready;
    logic [DATA_BITS-1:0] w_sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .rr_ptr  (r_rr_ptr),
        .any_req (w_any_req),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_state_d    = r_state;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        w_hold_enter = 1'b0;
        w_acc_idx    = grant_id;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_accept  = 1'b1;
                    w_acc_idx = w_gnt_idx;
                end
            end
            START: w_state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    if (!r_lock) begin
                        w_release = 1'b1;
                    end else if (req_valid[grant_id]) begin
                        w_accept = 1'b1;
                    end else if (LOCK_TIMEOUT == 0) begin
                        w_release = 1'b1;
                    end else begin
                        w_state_d    = HOLD;
                        w_hold_enter = 1'b1;
                    end
                end
            end
            HOLD: begin
                // An owner byte arriving on the final timeout cycle still wins.
                if (req_valid[grant_id]) begin
                    w_accept = 1'b1;
                end else if (int'(r_cnt) == LOCK_TIMEOUT - 1) begin
                    w_release = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
        if (w_accept)  w_state_d = START;
        if (w_release) w_state_d = IDLE;
    end

    always_comb begin
        w_ready = '0;
        if (w_accept) w_ready[w_acc_idx] = 1'b1;
    end

    assign req_ready  = w_ready & {NUM_REQ{reset_n}};
    assign w_sel_data = req_data[w_acc_idx*DATA_BITS +: DATA_BITS];
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_lock   <= 1'b0;
            r_cnt    <= '0;
            grant_id <= '0;
            tx_din   <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= w_accept;
            if (w_accept) begin
                tx_din   <= w_sel_data;
                grant_id <= w_acc_idx;
                r_lock   <= ~req_last[w_acc_idx];
            end
            if (w_release) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= IDW'(rr_next(32'(grant_id), NUM_REQ));
            end
            if (w_hold_enter)         r_cnt <= '0;
            else if (r_state == HOLD) r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire
